car_motion_controller: RTL
==========================

Name: car_motion_controller

Overview:
- Consumes `direction`/`should_move` from the direction-decision FSM and the registered call vector.
- Models car travel between floors and door open/close timing.
- Produces `current_floor`, which feeds back into the direction FSM, and one-hot call-clear pulses, which feed the call register.
- Sits directly downstream of the direction FSM; closes the control loop.

Parameters:
- FLOORS, 8, number of floors; bit i of the call vector corresponds to floor i.
- FLOOR_W, 3, width of the floor index; FLOORS ≤ 2^FLOOR_W.
- TRAVEL_CYCLES, 16, clock cycles to move one floor; must be ≥ 1.
- DOOR_CYCLES, 32, clock cycles the door stays open; must be ≥ 1.
- TIMER_W, 8, width of the shared countdown timer; must hold max(TRAVEL_CYCLES, DOOR_CYCLES) − 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- direction  in  1  requested direction from the direction FSM; 1 = up, 0 = down.
- should_move  in  1  direction FSM requests motion.
- floors_called  in  FLOORS  pending calls, bit per floor.
- door_hold  in  1  door-open button; holds the door open.
- current_floor  out  FLOOR_W  registered car position.
- call_clear  out  FLOORS  registered one-hot pulse; clears the served floor's call.
- door_open  out  1  registered; high in DOOR_OPEN.
- moving  out  1  registered; high in TRAVEL.
- state  out  2  FSM state, for debug.

Behaviour:
- Reset (async, any state, including mid-travel):
  - state=IDLE, current_floor=0, call_clear=0, door_open=0, moving=0, timer=0, latched dir=0.
  - Physical position is not preserved; the model restarts at floor 0.
- States: IDLE=0, TRAVEL=1, DOOR_OPEN=2, SETTLE=3.
- IDLE, priority order:
  - (a) floors_called[current_floor]=1: go to DOOR_OPEN; timer←DOOR_CYCLES−1; call_clear←onehot(current_floor) for exactly 1 cycle.
  - (b) else should_move=1 and the move is legal: latch direction; go to TRAVEL; timer←TRAVEL_CYCLES−1.
    - Legal = not (up at FLOORS−1) and not (down at 0).
  - (c) Illegal request or nothing pending: stay in IDLE.
- TRAVEL: moving=1; timer decrements each cycle. At timer==0, the next edge (arrival):
  - current_floor ← current_floor ± 1, per the latched dir.
  - nf = new floor. If floors_called[nf]: go to DOOR_OPEN; call_clear←onehot(nf); timer←DOOR_CYCLES−1.
  - Else if any call strictly beyond nf in the latched dir: stay in TRAVEL; timer←TRAVEL_CYCLES−1.
    - Continuing at a boundary floor is impossible, since nothing lies beyond it.
  - Else: go to SETTLE.
  - Net effect: each floor takes exactly TRAVEL_CYCLES cycles; should_move is ignored while in TRAVEL.
- DOOR_OPEN: door_open=1.
  - If door_hold=1, or floors_called[current_floor]=1 (re-press): timer←DOOR_CYCLES−1.
  - A re-press also issues a new call_clear pulse for current_floor.
  - Else if timer==0: go to SETTLE.
  - Else: timer decrements.
  - door_hold has priority over expiry when both occur in the same cycle.
- SETTLE: fixed 2 cycles (timer←1 on entry), then IDLE; all outputs idle.
  - Purpose: the registered direction FSM observes the updated floor and cleared calls before its outputs are trusted.
- Arithmetic:
  - current_floor never wraps; saturation is guaranteed by the legality checks.
  - Timer is unsigned and never decrements below 0.
- Latency:
  - IDLE with a call at the current floor sampled at edge N: door_open=1 and call_clear valid after edge N+1.
  - should_move sampled at N: moving=1 after N+1; floor changes at edge N+1+TRAVEL_CYCLES.
- call_clear is zero in every cycle except the pulse cycles listed above.

Decomposition:
- Package elevator_pkg: FLOORS, FLOOR_W, state encodings (ST_IDLE..ST_SETTLE), DIR_UP=1/DIR_DOWN=0.
- One sub-module, cycle_timer:
  - Loadable TIMER_W down-counter with load, load value, decrement enable, and `zero` flag.
  - Async-reset dffe style.
  - Shared by TRAVEL, DOOR_OPEN and SETTLE.
- "Calls beyond nf" is a combinational masked-OR inside the top module.

Test Plan (TRAVEL_CYCLES=4, DOOR_CYCLES=6):
- Reset, then floors_called=8'h01 at floor 0 → next cycle door_open=1, call_clear=8'h01 for 1 cycle; door_open stays high 6 cycles; 2 SETTLE cycles; back to IDLE.
- At floor 0, should_move=1, direction=1, floors_called=8'h08 → floor 1,2,3 reached every 4 cycles without stopping; at floor 3 call_clear=8'h08, door_open=1.
- At floor 7, should_move=1, direction=1 → stays IDLE, current_floor=7, moving=0; same for floor 0 with direction=0.
- door_hold asserted 10 cycles mid-DOOR_OPEN → door_open stays high through hold plus 6 cycles after release; a re-press of the current floor gives a second call_clear pulse.
- Assert reset mid-TRAVEL (floor 2→3, timer=2) → immediately state=IDLE, current_floor=0, moving=0, call_clear=0.
- Travel down from floor 5 with calls 8'h05: arrive floor 2, clear 8'h04, door cycle; re-dispatch down; arrive floor 0, clear 8'h01.

Source files
------------

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Shared constants, state encoding and helpers for the elevator
//               car control path.
// Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    localparam int FLOORS  = 8;
    localparam int FLOOR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_TRAVEL    = 2'd1,
        ST_DOOR_OPEN = 2'd2,
        ST_SETTLE    = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // One-hot vector with only the bit for floor f set.
    function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        logic [FLOORS-1:0] v;
        v = '0;
        v[f] = 1'b1;
        return v;
    endfunction

endpackage : elevator_pkg
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : cycle_timer
// Description : Loadable down-counter with zero flag. Load has priority over
//               decrement; the count never goes below zero.
// Ports       : clk, reset (async, active-high)
//               i_load / i_load_val : load a new count
//               i_dec               : decrement enable
//               o_zero              : count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_timer #(
    parameter int TIMER_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    input  logic               i_dec,
    output logic               o_zero
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule : cycle_timer
`default_nettype wire

// File: rtl/car_motion_controller.sv
`default_nettype none
// ============================================================================
// Module      : car_motion_controller
// Description : Moves the car floor by floor on request of the direction FSM,
//               runs the door cycle, and pulses one-hot call clears for the
//               floor being served.
// Ports       : clk, reset (async, active-high)
//               direction     : 1 = up, 0 = down
//               should_move   : motion request
//               floors_called : pending calls, bit per floor
//               door_hold     : keeps the door open
//               current_floor : registered car position
//               call_clear    : registered one-hot clear pulse
//               door_open     : registered, high in DOOR_OPEN
//               moving        : registered, high in TRAVEL
//               state         : FSM state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module car_motion_controller
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32,
    parameter int TIMER_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               direction,
    input  logic               should_move,
    input  logic [FLOORS-1:0]  floors_called,
    input  logic               door_hold,
    output logic [FLOOR_W-1:0] current_floor,
    output logic [FLOORS-1:0]  call_clear,
    output logic               door_open,
    output logic               moving,
    output logic [1:0]         state
);

    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [FLOOR_W-1:0]   r_floor;
    logic [FLOOR_W-1:0]   w_floor_nxt;
    logic                 r_dir;
    logic                 w_dir_nxt;
    logic [FLOORS-1:0]    r_call_clear;
    logic [FLOORS-1:0]    w_clear_nxt;
    logic                 r_door_open;
    logic                 r_moving;

    logic                 w_t_load;
    logic [TIMER_W-1:0]   w_t_val;
    logic                 w_t_dec;
    logic                 w_t_zero;

    logic [FLOOR_W-1:0]   w_nf;
    logic                 w_beyond;
    logic                 w_move_legal;

    cycle_timer #(
        .TIMER_W   (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_t_load),
        .i_load_val (w_t_val),
        .i_dec      (w_t_dec),
        .o_zero     (w_t_zero)
    );

    // Floor reached on the arrival edge; legality checks keep it in range.
    assign w_nf = (r_dir == DIR_UP) ? (r_floor + 1'b1) : (r_floor - 1'b1);

    assign w_move_legal = !((direction == DIR_UP)   && (r_floor == FLOOR_W'(FLOORS - 1))) &&
                          !((direction == DIR_DOWN) && (r_floor == '0));

    // Any call strictly past the arrival floor in the latched direction.
    always_comb begin
        w_beyond = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (floors_called[i]) begin
                if ((r_dir == DIR_UP) && (FLOOR_W'(i) > w_nf)) begin
                    w_beyond = 1'b1;
                end
                if ((r_dir == DIR_DOWN) && (FLOOR_W'(i) < w_nf)) begin
                    w_beyond = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_floor_nxt = r_floor;
        w_dir_nxt   = r_dir;
        w_clear_nxt = '0;
        w_t_load    = 1'b0;
        w_t_val     = '0;
        w_t_dec     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (floors_called[r_floor]) begin
                    w_state_nxt = ST_DOOR_OPEN;
                    w_t_load    = 1'b1;
                    w_t_val     = DOOR_LOAD;
                    w_clear_nxt = onehot(r_floor);
                end else if (should_move && w_move_legal) begin
                    w_dir_nxt   = direction;
                    w_state_nxt = ST_TRAVEL;
                    w_t_load    = 1'b1;
                    w_t_val     = TRAVEL_LOAD;
                end
            end
            ST_TRAVEL: begin
                if (!w_t_zero) begin
                    w_t_dec = 1'b1;
                end else begin
                    w_floor_nxt = w_nf;
                    w_t_load    = 1'b1;
                    if (floors_called[w_nf]) begin
                        w_state_nxt = ST_DOOR_OPEN;
                        w_t_val     = DOOR_LOAD;
                        w_clear_nxt = onehot(w_nf);
                    end else if (w_beyond) begin
                        w_t_val     = TRAVEL_LOAD;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                        w_t_val     = SETTLE_LOAD;
                    end
                end
            end
            ST_DOOR_OPEN: begin
                // Hold or a re-press restarts the door interval; a re-press
                // also clears the new call for this floor.
                if (door_hold || floors_called[r_floor]) begin
                    w_t_load = 1'b1;
                    w_t_val  = DOOR_LOAD;
                    if (floors_called[r_floor]) begin
                        w_clear_nxt = onehot(r_floor);
                    end
                end else if (w_t_zero) begin
                    w_state_nxt = ST_SETTLE;
                    w_t_load    = 1'b1;
                    w_t_val     = SETTLE_LOAD;
                end else begin
                    w_t_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                // Gives the registered direction FSM time to see the new floor
                // and the cleared calls before it is trusted again.
                if (w_t_zero) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_t_dec = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_floor      <= '0;
            r_dir        <= DIR_DOWN;
            r_call_clear <= '0;
            r_door_open  <= 1'b0;
            r_moving     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_floor      <= w_floor_nxt;
            r_dir        <= w_dir_nxt;
            r_call_clear <= w_clear_nxt;
            r_door_open  <= (w_state_nxt == ST_DOOR_OPEN);
            r_moving     <= (w_state_nxt == ST_TRAVEL);
        end
    end

    assign current_floor = r_floor;
    assign call_clear    = r_call_clear;
    assign door_open     = r_door_open;
    assign moving        = r_moving;
    assign state         = r_state;

endmodule : car_motion_controller
`default_nettype wire
